// File: rtl/fft_pkg.sv
// Shared constants, types and addressing helpers for the FFT stage reorder buffer.
// Frame size is fixed here; every FFT block in the datapath imports it.
package fft_pkg;
  localparam int N     = 16;
  localparam int LOG2N = $clog2(N);
  localparam int STW   = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);
  localparam int KW    = LOG2N - 1;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [KW-1:0]    pair_idx_t;
  typedef logic [STW-1:0]   stage_t;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  typedef struct packed {
    addr_t a;
    addr_t b;
  } addr_pair_t;

  function automatic addr_t bitrev(input addr_t x);
    addr_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // addr_a is k with a zero inserted at the 'half' bit; addr_b sets that bit.
  // Stages at or past the last one collapse to half = 1.
  function automatic addr_pair_t pair_addr(input stage_t s, input pair_idx_t k);
    addr_pair_t p;
    int         h;
    addr_t      kx;
    addr_t      lo_mask;
    addr_t      a;
    h       = (int'(s) >= LOG2N - 1) ? 0 : (LOG2N - 1 - int'(s));
    kx      = addr_t'(k);
    lo_mask = addr_t'((1 << h) - 1);
    a       = ((kx & ~lo_mask) << 1) | (kx & lo_mask);
    p.a     = a;
    p.b     = a | addr_t'(1 << h);
    return p;
  endfunction
endpackage

// File: rtl/fft_pair_addr.sv
// Combinational pair-address generator: in-place butterfly addressing for a stage,
// or bit-reversed natural-order addressing when final_mode is set.
module fft_pair_addr
  import fft_pkg::*;
(
  input  logic [STW-1:0]   stage,
  input  logic [KW-1:0]    k,
  input  logic             final_mode,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b
);
  addr_pair_t p;

  always_comb begin
    p      = pair_addr(stage, k);
    addr_a = p.a;
    addr_b = p.b;
    if (final_mode) begin
      addr_a = bitrev({k, 1'b0});
      addr_b = bitrev({k, 1'b1});
    end
  end
endmodule

// File: rtl/fft_stage_buffer.sv
// Ping-pong reorder buffer: captures one butterfly frame in stage-s order, replays it
// for stage s+1 (or bit-reversed after the last stage). 2-cycle fill, then 1 pair/cycle.
module fft_stage_buffer
  import fft_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [STW-1:0]   i_stage,
  input  logic [31:0]      i_A_real,
  input  logic [31:0]      i_A_imag,
  input  logic [31:0]      i_B_real,
  input  logic [31:0]      i_B_imag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_A_real,
  output logic [31:0]      o_A_imag,
  output logic [31:0]      o_B_real,
  output logic [31:0]      o_B_imag,
  output logic [STW-1:0]   o_stage,
  output logic             o_final,
  output logic             o_last
);
  complex_t       mem [2][N];
  logic [1:0]     full;
  stage_t         bank_stage [2];
  logic           wbank, rbank;
  logic [KW-1:0]  kw, kr;

  logic           in_fire, load, rd_final;
  stage_t         wr_stage, rd_stage, rd_addr_stage;
  addr_t          wa, wb, ra, rb;
  complex_t       rd_a, rd_b;

  assign o_in_ready    = !full[wbank];
  assign in_fire       = i_in_valid && o_in_ready;
  assign wr_stage      = (kw == '0) ? i_stage : bank_stage[wbank];
  assign rd_stage      = bank_stage[rbank];
  assign rd_final      = int'(rd_stage) >= LOG2N - 1;
  assign rd_addr_stage = rd_stage + 1'b1;
  assign load          = full[rbank] && (!o_valid || i_ready);
  assign rd_a          = mem[rbank][ra];
  assign rd_b          = mem[rbank][rb];

  fft_pair_addr u_wr_addr (
    .stage      (wr_stage),
    .k          (kw),
    .final_mode (1'b0),
    .addr_a     (wa),
    .addr_b     (wb)
  );

  fft_pair_addr u_rd_addr (
    .stage      (rd_addr_stage),
    .k          (kr),
    .final_mode (rd_final),
    .addr_a     (ra),
    .addr_b     (rb)
  );

  // Two write ports per bank: A and B land at distinct addresses of the same bank.
  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      mem[wbank][wa] <= {i_A_real, i_A_imag};
      mem[wbank][wb] <= {i_B_real, i_B_imag};
    end
  end

  // A write needs !full[wbank] and a load needs full[rbank], so the two sides
  // never touch the same bank's flag in one cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      full          <= '0;
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      kw            <= '0;
      kr            <= '0;
      bank_stage[0] <= '0;
      bank_stage[1] <= '0;
    end else begin
      if (in_fire) begin
        if (kw == '0) bank_stage[wbank] <= i_stage;
        if (&kw) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
          kw          <= '0;
        end else begin
          kw <= kw + 1'b1;
        end
      end
      if (load) begin
        if (&kr) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          kr          <= '0;
        end else begin
          kr <= kr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid  <= 1'b0;
      o_A_real <= '0;
      o_A_imag <= '0;
      o_B_real <= '0;
      o_B_imag <= '0;
      o_stage  <= '0;
      o_final  <= 1'b0;
      o_last   <= 1'b0;
    end else if (load) begin
      o_valid  <= 1'b1;
      o_A_real <= rd_a.re;
      o_A_imag <= rd_a.im;
      o_B_real <= rd_b.re;
      o_B_imag <= rd_b.im;
      o_stage  <= rd_final ? '0 : rd_addr_stage;
      o_final  <= rd_final;
      o_last   <= &kr;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_stage_buffer.sv
// Self-checking bench for fft_stage_buffer: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a frame-level reference model.
`timescale 1ns/1ps
module tb_fft_stage_buffer;
  import fft_pkg::*;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b0;
  logic           i_in_valid = 1'b0;
  logic           o_in_ready;
  logic [STW-1:0] i_stage = '0;
  logic [31:0]    i_A_real = '0, i_A_imag = '0, i_B_real = '0, i_B_imag = '0;
  logic           o_valid;
  logic           i_ready = 1'b0;
  logic [31:0]    o_A_real, o_A_imag, o_B_real, o_B_imag;
  logic [STW-1:0] o_stage;
  logic           o_final, o_last;

  always #5 i_clk = ~i_clk;

  fft_stage_buffer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_stage(i_stage), .i_A_real(i_A_real), .i_A_imag(i_A_imag),
    .i_B_real(i_B_real), .i_B_imag(i_B_imag), .o_valid(o_valid), .i_ready(i_ready),
    .o_A_real(o_A_real), .o_A_imag(o_A_imag), .o_B_real(o_B_real), .o_B_imag(o_B_imag),
    .o_stage(o_stage), .o_final(o_final), .o_last(o_last)
  );

  typedef struct {
    logic [31:0] ar, ai, br, bi;
    int          st;
    bit          fin, last;
    int          cyc;
  } rec_t;

  typedef struct {
    int          st;
    int          k;
    logic [31:0] a, b;
    int          ost;
    bit          fin, last;
  } vec_t;

  rec_t        expq[$];
  rec_t        gotq[$];
  logic [31:0] mre[N];
  logic [31:0] mim[N];
  int          mk = 0, mstage = 0;
  int          nchk = 0, nerr = 0;
  int          cyc = 0, last_in_cyc = 0;
  bit          stall_prev = 0;
  rec_t        prev;
  vec_t        tbl[7];

  function automatic logic [199:0] pk(input rec_t r);
    return {8'(r.st), 6'b0, r.fin, r.last, r.ar, r.ai, r.br, r.bi};
  endfunction

  function automatic void chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LOG2N; i++)
      if (((x >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // Reference model: rebuild the whole frame as an N-point array, then list the
  // pairs the next stage (or the natural-order output) would read from it.
  function automatic void model_accept(input int st, input logic [31:0] ar, ai, br, bi);
    int s, half, a;
    if (mk == 0) mstage = st;
    s    = (mstage > LOG2N - 1) ? LOG2N - 1 : mstage;
    half = N >> (s + 1);
    a    = 2 * (mk / half) * half + (mk % half);
    mre[a] = ar; mim[a] = ai; mre[a + half] = br; mim[a + half] = bi;
    mk++;
    if (mk == N / 2) begin
      for (int k = 0; k < N / 2; k++) begin
        rec_t r;
        int   ia, ib, h;
        if (mstage < LOG2N - 1) begin
          h  = N >> (mstage + 2);
          ia = 2 * (k / h) * h + (k % h);
          ib = ia + h;
          r.st = mstage + 1; r.fin = 0;
        end else begin
          ia = brev(2 * k);
          ib = brev(2 * k + 1);
          r.st = 0; r.fin = 1;
        end
        r.ar = mre[ia]; r.ai = mim[ia]; r.br = mre[ib]; r.bi = mim[ib];
        r.last = (k == N / 2 - 1);
        r.cyc  = 0;
        expq.push_back(r);
      end
      mk = 0;
    end
  endfunction

  always @(negedge i_clk) begin
    rec_t g;
    rec_t e;
    cyc++;
    g.ar = o_A_real; g.ai = o_A_imag; g.br = o_B_real; g.bi = o_B_imag;
    g.st = int'(o_stage); g.fin = o_final; g.last = o_last; g.cyc = cyc;
    if (!i_reset) begin
      mk = 0;
      expq.delete();
      stall_prev = 0;
      chk("reset_outputs", {o_valid, o_in_ready, pk(g)}, {1'b0, 1'b1, 200'b0});
    end else begin
      if (i_in_valid && o_in_ready) begin
        model_accept(int'(i_stage), i_A_real, i_A_imag, i_B_real, i_B_imag);
        last_in_cyc = cyc;
      end
      if (o_valid && !i_ready && stall_prev) chk("stall_hold", pk(g), pk(prev));
      stall_prev = o_valid && !i_ready;
      prev = g;
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_output: got pair A=%0h B=%0h, expected none", g.ar, g.br);
        end else begin
          e = expq.pop_front();
          chk("pair_out", pk(g), pk(e));
        end
        gotq.push_back(g);
      end
    end
  end

  task automatic send_pair(input int st, input logic [31:0] a, b, input int tmo, output bit ok);
    int t = 0;
    i_in_valid = 1'b1; i_stage = STW'(st);
    i_A_real = a; i_A_imag = ~a; i_B_real = b; i_B_imag = ~b;
    ok = 0;
    while (t < tmo) begin
      @(negedge i_clk);
      if (o_in_ready) begin ok = 1; break; end
      t++;
    end
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
  endtask

  // mode 0: A=k, B=k+8; mode 1: A=2k, B=2k+1; mode 2: random. tag lands in bits 31:16.
  task automatic send_frame(input int st, input int mode, input int tag, input bit gaps, input int npairs);
    bit ok;
    logic [31:0] a, b;
    for (int k = 0; k < npairs; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge i_clk); #1; end
      case (mode)
        0:       begin a = 32'(k);     b = 32'(k + 8);     end
        1:       begin a = 32'(2 * k); b = 32'(2 * k + 1); end
        default: begin a = $urandom;   b = $urandom;       end
      endcase
      if (mode != 2) begin a |= 32'(tag) << 16; b |= 32'(tag) << 16; end
      send_pair(st, a, b, 300, ok);
      if (!ok) begin
        nchk++; nerr++;
        $display("FAIL send_timeout: pair %0d not accepted, expected acceptance", k);
      end
    end
  endtask

  task automatic wait_drain(input int tmo);
    int t = 0;
    while ((expq.size() != 0 || o_valid) && t < tmo) begin
      @(posedge i_clk); #2;
      t++;
    end
    chk("drain_empty", {o_valid, 32'(expq.size())}, 0);
  endtask

  task automatic check_table(input int st);
    rec_t e;
    chk("frame_size", 32'(gotq.size()), 8);
    foreach (tbl[i]) begin
      if (tbl[i].st == st && gotq.size() > tbl[i].k) begin
        e.ar = tbl[i].a; e.ai = ~tbl[i].a; e.br = tbl[i].b; e.bi = ~tbl[i].b;
        e.st = tbl[i].ost; e.fin = tbl[i].fin; e.last = tbl[i].last; e.cyc = 0;
        chk("table_pair", pk(gotq[tbl[i].k]), pk(e));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit done;
    tbl[0] = '{0, 0, 32'd0,  32'd4,  1, 0, 0};
    tbl[1] = '{0, 3, 32'd3,  32'd7,  1, 0, 0};
    tbl[2] = '{0, 4, 32'd8,  32'd12, 1, 0, 0};
    tbl[3] = '{0, 7, 32'd11, 32'd15, 1, 0, 1};
    tbl[4] = '{3, 0, 32'd0,  32'd8,  0, 1, 0};
    tbl[5] = '{3, 1, 32'd4,  32'd12, 0, 1, 0};
    tbl[6] = '{3, 7, 32'd7,  32'd15, 0, 1, 1};

    // Reset held under random stimulus; the monitor checks outputs every cycle.
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      i_in_valid = 1'($urandom); i_ready = 1'($urandom); i_stage = STW'($urandom);
      i_A_real = $urandom; i_B_real = $urandom;
    end
    i_in_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #2;
      chk("post_reset_idle", {o_valid, o_in_ready}, 2'b01);
    end

    // Stage 0 frame, with fill-latency check.
    gotq.delete();
    send_frame(0, 0, 0, 0, 8);
    wait_drain(100);
    check_table(0);
    if (gotq.size() > 0) chk("fill_latency", 32'(gotq[0].cyc - last_in_cyc), 2);

    // Final stage frame, bit-reversed output.
    gotq.delete();
    send_frame(3, 1, 0, 0, 8);
    wait_drain(100);
    check_table(3);

    // Backpressure: two frames fill both banks, third waits.
    i_ready = 1'b0;
    gotq.delete();
    send_frame(1, 2, 1, 0, 8);
    send_frame(2, 2, 2, 0, 8);
    @(posedge i_clk); #2;
    chk("bp_ready_low_after_16", o_in_ready, 0);
    send_pair(0, 32'h1, 32'h2, 10, ok);
    chk("bp_third_blocked", ok, 0);
    i_ready = 1'b1;
    send_frame(0, 2, 3, 0, 8);
    wait_drain(200);
    chk("bp_total_pairs", 32'(gotq.size()), 24);

    // Streaming four frames back to back.
    gotq.delete();
    for (int f = 0; f < 4; f++) send_frame(f, 2, f, 0, 8);
    wait_drain(200);
    chk("stream_pairs", 32'(gotq.size()), 32);
    if (gotq.size() == 32) chk("stream_gapless", 32'(gotq[31].cyc - gotq[0].cyc), 31);

    // Reset five pairs into a frame.
    send_frame(0, 2, 5, 0, 5);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1 chk("ready_after_reset", o_in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #2;
      chk("no_valid_after_reset", o_valid, 0);
    end
    gotq.delete();
    send_frame(0, 0, 0, 0, 8);
    wait_drain(100);
    check_table(0);

    // Randomized traffic with random backpressure.
    done = 0;
    fork
      begin
        for (int f = 0; f < 12; f++) send_frame($urandom_range(0, 3), 2, f, 1, 8);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    wait_drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fft_stage_buffer.md
# fft_stage_buffer

Ping-pong reorder buffer downstream of the registered radix-2 butterfly in the CORDIC-based FFT datapath. It captures one frame of butterfly output pairs (A', B') for DIF stage s, written in place at that stage's addresses. It then replays the frame as operand pairs addressed for stage s+1, or in natural order after the last stage. Data words are opaque IEEE-754 single-precision bit patterns; the block performs no arithmetic on them.

## Interface
- N, default 16: FFT points; power of two, ≥4. LOG2N = $clog2(N); STW = max(1, $clog2(LOG2N)).
- i_clk, input, 1: clock.
- i_reset, input, 1: asynchronous, active-low reset.
- i_in_valid, input, 1: input pair present.
- o_in_ready, output, 1: input pair can be accepted.
- i_stage, input, STW: stage of the incoming pair; only sampled on pair 0 of a frame.
- i_A_real, i_A_imag, i_B_real, i_B_imag, input, 32 each: butterfly outputs.
- o_valid, output, 1: output pair present.
- i_ready, input, 1: consumer accepts the output pair.
- o_A_real, o_A_imag, o_B_real, o_B_imag, output, 32 each: next-stage operand pair.
- o_stage, output, STW: stage the output pair belongs to (s+1; 0 when final).
- o_final, output, 1: pair is natural-order FFT output.
- o_last, output, 1: last pair of the frame.

## Operation
- Two banks, each N×64 bits (real, imag); plus per bank: full flag and latched stage.
- Write pointer wbank and read pointer rbank, each 1 bit.
- Write counter kw and read counter kr, each LOG2N-1 bits.
- Pair addressing for stage s and pair k: half = N>>(s+1); g = k/half; j = k%half; addr_a = 2·g·half + j; addr_b = addr_a + half.
- Write side:
  - o_in_ready = !full[wbank].
  - An input handshake writes A to addr_a and B to addr_b of bank wbank, using pair kw and the bank's stage. On kw=0 the stage is taken from i_stage.
  - On kw = N/2-1: set full[wbank], toggle wbank, clear kw.
- Read side, when full[rbank] and the output register is empty or being drained (o_valid=0 or i_ready=1):
  - Non-final, s < LOG2N-1: load pair kr using stage s+1 addressing; o_stage = s+1; o_final = 0.
  - Final, s ≥ LOG2N-1: load A from address bitrev(2kr) and B from bitrev(2kr+1); o_final = 1; o_stage = 0.
  - o_last = (kr = N/2-1).
  - On loading the last pair: clear full[rbank], toggle rbank, clear kr.
- Output register holds its value, stable, while o_valid=1 and i_ready=0.
- Write into one bank and read from the other in the same cycle is legal and must not stall.
- Both banks full: o_in_ready=0 until a bank's last pair is loaded into the output register.
- i_stage values above LOG2N-1 are treated as final.

## Timing
- Reset (async assert, sync release): o_valid, o_final, o_last and o_stage = 0; all data outputs = 0. Banks are empty, wbank = rbank = 0, kw = kr = 0, o_in_ready = 1. Bank contents need no reset.
- Reset mid-frame discards partial and full frames. o_in_ready = 1 on the first cycle after release.
- Latency: last input handshake at edge E sets full at E. The first pair loads at E+1, and o_valid = 1 from E+1.
- Throughput: one pair per cycle in and out. With i_ready held high, a frame drains in N/2 consecutive cycles.
- o_in_ready depends only on registered state; there is no combinational path from i_in_valid.

## Structure
- Package fft_pkg holds:
  - N and LOG2N constants.
  - complex_t struct of 32-bit real and imag.
  - bitrev function.
  - pair_addr function (stage, k) returning addr_a and addr_b.
- One combinational sub-module, fft_pair_addr, instantiated twice: once for the write side and once for the read side; the read-side instance carries the final/bit-reversed mode.
- Banks are flop arrays; two write ports per bank are required.

## Test plan
All scenarios use N=16, with data tagged so that A_real of pair k = k and B_real = k+8, and imag = ~real.
- Reset: hold i_reset=0 during random stimulus -> all outputs 0, o_in_ready=1. Release -> o_valid=0 until a frame completes.
- Stage 0 frame, i_ready=1 -> bank[m] holds m. Output pairs are k0→(0,4), k3→(3,7), k4→(8,12), k7→(11,15); o_stage=1, o_final=0, o_last only on k7.
- Stage 3 frame (half=1; pair k writes addresses 2k and 2k+1, data 2k and 2k+1) -> outputs k0→(0,8), k1→(4,12), k7→(7,15); o_final=1.
- Backpressure: i_ready=0, three frames offered -> o_in_ready falls after pair 15 (the 16th accepted pair) and stays low. Raise i_ready -> first frame emerges intact, then the third frame is accepted.
- Streaming: continuous valid/ready over 4 frames -> no gaps after the first frame's 2-cycle fill latency; ordering and o_last are correct.
- Reset asserted after 5 pairs of a frame -> no o_valid afterwards. A subsequent full frame is emitted correctly, starting from kw=0.
